// File: rtl/rv_pkg.sv
// RV32I definitions shared by fetch predecode and the sign extender: opcodes,
// immediate-format select, fetch buffer entry and the default reset PC.
package rv_pkg;

   localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_I = 3'h0,
      IMM_B = 3'h1,
      IMM_U = 3'h2,
      IMM_J = 3'h3,
      IMM_S = 3'h4
   } imm_sel_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   // Formats without an immediate (R-type, fence) fall back to I; decode ignores it.
   function automatic imm_sel_e imm_sel_of(input logic [6:0] op);
      case (op)
         OP_BRANCH:        return IMM_B;
         OP_LUI, OP_AUIPC: return IMM_U;
         OP_JAL:           return IMM_J;
         OP_STORE:         return IMM_S;
         default:          return IMM_I;
      endcase
   endfunction

   function automatic logic opcode_legal(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_BRANCH, OP_LUI,
         OP_AUIPC, OP_JAL, OP_STORE, OP_REG, OP_FENCE: return 1'b1;
         default:                                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ifetch_buf.sv
// BUF_DEPTH-entry FIFO of {pc, instr}; head shown combinationally, zeros while empty.
// Flush wins over push/pop; caller never pushes into a full buffer unless popping.
module ifetch_buf
   import rv_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  fetch_entry_t               push_entry,
   input  logic                       pop,
   output logic                       head_valid,
   output fetch_entry_t               head,
   output logic [$clog2(BUF_DEPTH):0] count
);

   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem [BUF_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage needs no reset: the head is masked whenever count is zero.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_entry;
   end

   assign head_valid = (count != '0);
   assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, request credits, redirect drop accounting, buffer, imm-select predecode.
// rsp->id_valid 1 cycle; requests stall while outstanding+buffered reach BUF_DEPTH. Option: IFETCH_ILLEGAL_DET_EN.
module instr_fetch
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RV_RESET_PC,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [24:0] id_imm_field,
   output logic [2:0]  id_imm_sel,
   output logic        id_illegal
);

   localparam int CW = $clog2(BUF_DEPTH) + 1;

   logic          started;
   logic [31:0]   pc;
   logic [31:0]   rsp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] occupancy;
   logic [CW-1:0] out_nxt;
   logic [CW:0]   credit_used;
   logic          accept;
   logic          drop;
   logic          push;
   logic          pop;
   logic [31:0]   target_pc;
   logic [1:0]    unused_redirect_lsbs;
   fetch_entry_t  head;

   assign target_pc            = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = redirect_pc[1:0];

   // Credits look only at registered state, so a pop this cycle frees a slot next cycle.
   assign credit_used    = {1'b0, outstanding} + {1'b0, occupancy};
   assign imem_req_valid = started && !redirect_valid && (credit_used < (CW+1)'(BUF_DEPTH));
   assign imem_req_addr  = pc;
   assign accept         = imem_req_valid && imem_req_ready;

   assign drop    = imem_rsp_valid && (drop_cnt != '0);
   assign push    = imem_rsp_valid && !drop && !redirect_valid;
   assign pop     = id_valid && id_ready;
   assign out_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started     <= 1'b0;
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         started     <= 1'b1;
         outstanding <= out_nxt;
         if (redirect_valid) begin
            // Everything still in flight belongs to the abandoned stream.
            pc       <= target_pc;
            rsp_pc   <= target_pc;
            drop_cnt <= out_nxt;
         end else begin
            if (accept) pc       <= pc + 32'd4;
            if (push)   rsp_pc   <= rsp_pc + 32'd4;
            if (drop)   drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   ifetch_buf #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry ('{pc: rsp_pc, instr: imem_rsp_data}),
      .pop        (pop),
      .head_valid (id_valid),
      .head       (head),
      .count      (occupancy)
   );

   assign id_instr     = head.instr;
   assign id_pc        = head.pc;
   assign id_imm_field = head.instr[31:7];
   assign id_imm_sel   = imm_sel_of(head.instr[6:0]);

`ifdef IFETCH_ILLEGAL_DET_EN
   assign id_illegal = id_valid && ((head.instr[1:0] != 2'b11) || !opcode_legal(head.instr[6:0]));
`else
   assign id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a queue model of memory and of the decode-side
// instruction stream predicts every request and every word presented to decode.
module tb_instr_fetch;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [24:0] id_imm_field;
   logic [2:0]  id_imm_sel;
   logic        id_illegal;

   always #5 clk = ~clk;

   instr_fetch #(
      .RESET_PC  (RPC),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_imm_field   (id_imm_field),
      .id_imm_sel     (id_imm_sel),
      .id_illegal     (id_illegal)
   );

   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { logic [31:0] addr; int due; } pend_t;

   ent_t  m_buf[$];
   pend_t mem_q[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    m_out = 0;
   int    m_drop = 0;
   int    last_due = 0;
   int    n_acc = 0;
   int    lat_lo = 1;
   int    lat_hi = 1;
   bit    m_started = 1'b0;
   bit    want_first = 1'b0;
   logic [31:0] m_pc = RPC;
   logic [31:0] first_target = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [6:0] opc_tab(input logic [3:0] i);
      case (i)
         4'd0:  return 7'h03;
         4'd1:  return 7'h13;
         4'd2:  return 7'h67;
         4'd3:  return 7'h73;
         4'd4:  return 7'h63;
         4'd5:  return 7'h37;
         4'd6:  return 7'h17;
         4'd7:  return 7'h6F;
         4'd8:  return 7'h23;
         4'd9:  return 7'h33;
         4'd10: return 7'h0F;
         4'd11: return 7'h00;
         4'd12: return 7'h7F;
         4'd13: return 7'h2B;
         4'd14: return 7'h10;
         default: return 7'h13;
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'h200: return 32'h00C0_006F;
         32'h204: return 32'hFE20_8EE3;
         32'h208: return 32'h0000_0000;
         32'h20C: return 32'h0000_0013;
         default: begin
            h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
            return {h[31:7], opc_tab(h[6:3])};
         end
      endcase
   endfunction

   function automatic logic [2:0] exp_sel(input logic [31:0] w);
      case (w[6:0])
         7'h63:        return 3'h1;
         7'h37, 7'h17: return 3'h2;
         7'h6F:        return 3'h3;
         7'h23:        return 3'h4;
         default:      return 3'h0;
      endcase
   endfunction

`ifdef IFETCH_ILLEGAL_DET_EN
   function automatic logic exp_ill(input logic [31:0] w);
      case (w[6:0])
         7'h03, 7'h13, 7'h67, 7'h73, 7'h63, 7'h37, 7'h17,
         7'h6F, 7'h23, 7'h33, 7'h0F: return 1'b0;
         default:                    return 1'b1;
      endcase
   endfunction
`endif

   task automatic do_reset();
      @(negedge clk);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      id_ready       = 1'b0;
      imem_req_ready = 1'b0;
      #1;
      check_eq("rst_req_valid", imem_req_valid, 32'd0);
      check_eq("rst_req_addr", imem_req_addr, RPC);
      check_eq("rst_id_valid", id_valid, 32'd0);
      check_eq("rst_id_instr", id_instr, 32'd0);
      check_eq("rst_id_pc", id_pc, 32'd0);
      check_eq("rst_imm_field", {7'd0, id_imm_field}, 32'd0);
      check_eq("rst_imm_sel", id_imm_sel, 32'd0);
      check_eq("rst_illegal", id_illegal, 32'd0);
      m_buf.delete();
      mem_q.delete();
      m_started = 1'b0;
      m_out     = 0;
      m_drop    = 0;
      m_pc      = RPC;
      last_due  = cyc;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // One clock cycle: drive inputs, compare against the model, then advance the model.
   task automatic step(input bit red, input logic [31:0] rpc, input bit idr, input bit rqr);
      bit          exp_rv;
      bit          acc;
      bit          pop;
      bit          rv;
      int          lat;
      int          out_after;
      logic [31:0] raddr;
      ent_t        h;
      @(negedge clk);
      rv    = 1'b0;
      raddr = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rv    = 1'b1;
         raddr = mem_q[0].addr;
         void'(mem_q.pop_front());
      end
      imem_rsp_valid = rv;
      imem_rsp_data  = rv ? mem_word(raddr) : 32'h0;
      redirect_valid = red;
      redirect_pc    = rpc;
      id_ready       = idr;
      imem_req_ready = rqr;
      #1;
      exp_rv = m_started && (m_out + m_buf.size() < DEPTH) && !red;
      check_eq("req_valid", imem_req_valid, 32'(exp_rv));
      check_eq("req_addr", imem_req_addr, m_pc);
      check_eq("id_valid", id_valid, 32'(m_buf.size() > 0));
      if (m_buf.size() > 0) begin
         h = m_buf[0];
         check_eq("id_pc", id_pc, h.pc);
         check_eq("id_instr", id_instr, h.instr);
         check_eq("imm_field", {7'd0, id_imm_field}, {7'd0, h.instr[31:7]});
         check_eq("imm_sel", id_imm_sel, exp_sel(h.instr));
`ifdef IFETCH_ILLEGAL_DET_EN
         check_eq("illegal", id_illegal, 32'(exp_ill(h.instr)));
`else
         check_eq("illegal", id_illegal, 32'd0);
`endif
      end
      acc = exp_rv && rqr;
      pop = (m_buf.size() > 0) && idr;
      if (acc) begin
         n_acc++;
         lat = int'($urandom_range(lat_hi, lat_lo));
         last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         mem_q.push_back('{m_pc, last_due});
      end
      if (pop) begin
         if (want_first) begin
            check_eq("first_pc_after_redirect", id_pc, first_target);
            want_first = 1'b0;
         end
         void'(m_buf.pop_front());
      end
      out_after = m_out + int'(acc) - int'(rv);
      if (red) begin
         m_buf.delete();
         m_pc   = {rpc[31:2], 2'b00};
         m_drop = out_after;
      end else begin
         if (acc) m_pc = m_pc + 32'd4;
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else m_buf.push_back('{raddr, mem_word(raddr)});
         end
      end
      m_out     = out_after;
      m_started = 1'b1;
      cyc++;
   endtask

   initial begin
      logic [31:0] rpc;
      int          guard;

      do_reset();
      repeat (20) step(1'b0, '0, 1'b1, 1'b1);

      // Decode stalled from an empty pipe: exactly BUF_DEPTH requests go out.
      do_reset();
      n_acc = 0;
      repeat (10) step(1'b0, '0, 1'b0, 1'b1);
      check_eq("stall_reqs", n_acc, DEPTH);
      repeat (12) step(1'b0, '0, 1'b1, 1'b1);

      // Slow memory so two responses are in flight when the redirect hits.
      lat_lo = 4;
      lat_hi = 4;
      step(1'b1, 32'h80, 1'b1, 1'b1);
      guard = 0;
      while (m_out < 2 && guard < 20) begin
         step(1'b0, '0, 1'b1, 1'b1);
         guard++;
      end
      check_eq("two_outstanding", m_out, 2);
      step(1'b1, 32'h100, 1'b1, 1'b1);
      first_target = 32'h100;
      want_first   = 1'b1;
      for (int i = 0; i < 30 && want_first; i++) step(1'b0, '0, 1'b1, 1'b1);
      check_eq("redirect_timeout", want_first, 32'd0);

      // Misaligned target and the JAL/BEQ/zero/NOP words at 0x200.
      lat_lo = 1;
      lat_hi = 1;
      step(1'b1, 32'h102, 1'b1, 1'b1);
      @(posedge clk);
      #1 check_eq("redir_align", imem_req_addr, 32'h100);
      step(1'b1, 32'h200, 1'b1, 1'b1);
      repeat (16) step(1'b0, '0, 1'b1, 1'b1);

      lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 500) do_reset();
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 1023));
         step($urandom_range(0, 99) < 4, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
